// File: rtl/can_rx_bit_sequencer_if.sv
// CAN receive bit-sequencer port bundle: raw line in, destuffed bit stream and frame events out.
interface can_rx_bit_sequencer_if;
  logic can_rx;
  logic rx_bit;
  logic rx_bit_valid;
  logic sof_pulse;
  logic frame_end;
  logic stuff_err;
  logic bus_idle;

  modport master (output can_rx,
                  input  rx_bit, rx_bit_valid, sof_pulse, frame_end, stuff_err, bus_idle);
  modport slave  (input  can_rx,
                  output rx_bit, rx_bit_valid, sof_pulse, frame_end, stuff_err, bus_idle);
endinterface

// File: rtl/can_rx_bit_sequencer.sv
// CAN RX bit timing, bus integration, hard sync at SOF, destuffing and end-of-frame detection.
// Optional macro CAN_RESYNC_EN: falling edges in RX/TAIL also re-zero the bit phase.
module can_rx_bit_sequencer #(
  parameter int CLK_FREQ_MHZ   = 100,
  parameter int BIT_RATE_KBITS = 1000,
  parameter int SAMPLE_PCT     = 75
) (
  input  logic                    clk,
  input  logic                    rst_n,
  can_rx_bit_sequencer_if.slave   bus
);
  localparam int N  = CLK_FREQ_MHZ * 1000 / BIT_RATE_KBITS;
  localparam int SP = N * SAMPLE_PCT / 100;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] PH_MAX = PW'(N - 1);
  localparam logic [PW-1:0] PH_SMP = PW'(SP);

  typedef enum logic [2:0] {INTEGRATE, READY, RX, TAIL, ERROR} state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rxs, rxs_d;
  logic [PW-1:0]   phase, phase_eff, phase_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [2:0]      run_cnt, run_cnt_nxt;
  logic            run_val, run_val_nxt;
  logic            rx_bit_q;
  logic            fall, hsync, smp;
  logic            valid, sof, fend, serr;

  always_comb begin
    fall = rxs_d & ~rxs;
`ifdef CAN_RESYNC_EN
    hsync = fall & (state inside {READY, RX, TAIL});
`else
    hsync = fall & (state == READY);
`endif
    // the sync cycle itself counts as phase 0, so the sample lands exactly SP clocks later
    phase_eff = hsync ? '0 : phase;
    phase_nxt = (phase_eff == PH_MAX) ? '0 : phase_eff + 1'b1;
    smp       = (phase_eff == PH_SMP);
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    run_cnt_nxt = run_cnt;
    run_val_nxt = run_val;
    valid       = 1'b0;
    sof         = 1'b0;
    fend        = 1'b0;
    serr        = 1'b0;
    case (state)
      INTEGRATE, ERROR: begin
        if (smp) begin
          if (!rxs)              cnt_nxt = '0;
          else if (cnt == 4'd10) begin cnt_nxt = '0; state_nxt = READY; end
          else                   cnt_nxt = cnt + 4'd1;
        end
      end
      READY: begin
        cnt_nxt = '0;
        if (fall) begin
          sof         = 1'b1;
          run_cnt_nxt = '0;
          state_nxt   = RX;
        end
      end
      RX: begin
        if (smp) begin
          if (run_cnt == 3'd5) begin
            if (rxs != run_val) begin
              run_val_nxt = rxs;
              run_cnt_nxt = 3'd1;
            end else if (!rxs) begin
              serr      = 1'b1;
              cnt_nxt   = '0;
              state_nxt = ERROR;
            end else begin
              // sixth recessive: end of stuffed region, recessive run continues in TAIL
              valid     = 1'b1;
              cnt_nxt   = 4'd6;
              state_nxt = TAIL;
            end
          end else begin
            valid = 1'b1;
            if (run_cnt != '0 && rxs == run_val) run_cnt_nxt = run_cnt + 3'd1;
            else begin
              run_val_nxt = rxs;
              run_cnt_nxt = 3'd1;
            end
          end
        end
      end
      TAIL: begin
        if (smp) begin
          valid = 1'b1;
          if (!rxs)              cnt_nxt = '0;
          else if (cnt == 4'd10) begin cnt_nxt = '0; fend = 1'b1; state_nxt = READY; end
          else                   cnt_nxt = cnt + 4'd1;
        end
      end
      default: state_nxt = INTEGRATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_d    <= 1'b1;
      state    <= INTEGRATE;
      phase    <= '0;
      cnt      <= '0;
      run_cnt  <= '0;
      run_val  <= 1'b1;
      rx_bit_q <= 1'b1;
    end else begin
      rx_meta  <= bus.can_rx;
      rxs      <= rx_meta;
      rxs_d    <= rxs;
      state    <= state_nxt;
      phase    <= phase_nxt;
      cnt      <= cnt_nxt;
      run_cnt  <= run_cnt_nxt;
      run_val  <= run_val_nxt;
      if (valid) rx_bit_q <= rxs;
    end
  end

  assign bus.rx_bit       = valid ? rxs : rx_bit_q;
  assign bus.rx_bit_valid = valid;
  assign bus.sof_pulse    = sof;
  assign bus.frame_end    = fend;
  assign bus.stuff_err    = serr;
  assign bus.bus_idle     = (state == READY);
endmodule
